pc_select_reg: RTL and testbench

Parametrised next-PC selector fused with the fetch-stage PC register. It chooses among NSRC next-PC candidates (PC+4, branch/jump target, register target, ...), holds on stall, and redirects on exception entry or ERET. It also tracks the branch-delay-slot flag and the fetch address-error flag for the CP0/exception path. It sits at the F stage and drives the IM address and the F/D pipeline register.

---
 rtl/pc_select_reg.sv | 72 +++++++
 tb/tb_pc_select_reg.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pc_select_reg.sv
// Fetch-stage PC register with its next-PC selector.
// Chooses the next fetch address from NSRC candidates, holds on stall,
// redirects on exception entry or ERET, and tracks the delay-slot and
// fetch-address-error flags for the exception path.
module pc_select_reg #(
  parameter int               WIDTH    = 32,
  parameter int               NSRC     = 3,
  parameter int               SELW     = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h00003000),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h00004180),
  parameter logic [WIDTH-1:0] IMEM_LO  = WIDTH'(32'h00003000),
  parameter logic [WIDTH-1:0] IMEM_HI  = WIDTH'(32'h00006ffc)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] src,
  input  logic                  stall,
  input  logic                  is_branch_D,
  input  logic                  exc_req,
  input  logic                  eret_req,
  input  logic [WIDTH-1:0]      epc,
  output logic [WIDTH-1:0]      pc,
  output logic [WIDTH-1:0]      pc_plus4,
  output logic                  bd_F,
  output logic                  adel_F,
  output logic                  kill_D
);

  logic [WIDTH-1:0] next_norm;

  // Candidate mux; an index with no matching candidate falls back to RESET_PC
  // so the PC never picks up X from an unpopulated slot.
  always_comb begin
    next_norm = RESET_PC;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) next_norm = src[k*WIDTH +: WIDTH];
    end
  end

  // PC, delay-slot flag and F/D kill; priority reset > exc > stall > eret > normal.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      bd_F   <= 1'b0;
      kill_D <= 1'b0;
    end else if (exc_req) begin
      pc     <= EXC_VEC;
      bd_F   <= 1'b0;
      kill_D <= 1'b1;
    end else if (stall) begin
      // A pending ERET is dropped here; the requester re-asserts it later.
      kill_D <= 1'b0;
    end else if (eret_req) begin
      // ERET has no delay slot, so bd_F clears.
      pc     <= epc;
      bd_F   <= 1'b0;
      kill_D <= 1'b1;
    end else begin
      pc     <= next_norm;
      bd_F   <= is_branch_D;
      kill_D <= 1'b0;
    end
  end

  // Sequential PC and fetch-address check, both purely from the current pc.
  always_comb begin
    pc_plus4 = pc + WIDTH'(4);
    adel_F   = (pc[1:0] != 2'b00) | (pc < IMEM_LO) | (pc > IMEM_HI);
  end

endmodule

// File: tb/tb_pc_select_reg.sv
// Scoreboard bench for pc_select_reg: the driver pushes hand-computed
// expected state per cycle; a monitor pops and compares after each edge.
module tb_pc_select_reg;

  logic        clk = 1'b0;
  logic        reset, stall, is_branch_D, exc_req, eret_req;
  logic [1:0]  sel;
  logic [31:0] src1, src2, epc;
  logic [95:0] src;
  logic [31:0] pc, pc_plus4;
  logic        bd_F, adel_F, kill_D;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic        bd;
    logic        kill;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  // Candidate 0 is the sequential address, candidate 1 is the test target.
  assign src = {src2, src1, pc_plus4};

  pc_select_reg dut (
    .clk(clk), .reset(reset), .sel(sel), .src(src), .stall(stall),
    .is_branch_D(is_branch_D), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .pc(pc), .pc_plus4(pc_plus4), .bd_F(bd_F),
    .adel_F(adel_F), .kill_D(kill_D)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input string nm, input logic rst, stl, exc, ert, isb,
                      input logic [1:0] s, input logic [31:0] s1, ep,
                      input logic [31:0] e_pc, input logic e_bd, e_kill, e_adel);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; exc_req = exc; eret_req = ert;
    is_branch_D = isb; sel = s; src1 = s1; epc = ep;
    e.pc = e_pc; e.p4 = e_pc + 32'd4; e.bd = e_bd; e.kill = e_kill; e.adel = e_adel;
    exp_q.push_back(e);
    if (nm.len() == 0) $display("unnamed vector");
  endtask

  // Monitor: compare the registered state just after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc !== e.pc || pc_plus4 !== e.p4 || bd_F !== e.bd ||
            kill_D !== e.kill || adel_F !== e.adel) begin
          errors++;
          $display("FAIL vec%0d: got pc=%h p4=%h bd=%b kill=%b adel=%b, want pc=%h p4=%h bd=%b kill=%b adel=%b",
                   vectors, pc, pc_plus4, bd_F, kill_D, adel_F,
                   e.pc, e.p4, e.bd, e.kill, e.adel);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
    is_branch_D = 1'b0; sel = 2'd0; src1 = '0; src2 = '0; epc = '0;
    //     name     rst stl exc ert isb sel src1          epc           pc            bd kill adel
    step("rst0",   1, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h00003000, 0, 0, 0);
    step("rst1",   1, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h00003000, 0, 0, 0);
    step("run1",   0, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h00003004, 0, 0, 0);
    step("run2",   0, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h00003008, 0, 0, 0);
    step("run3",   0, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0000300c, 0, 0, 0);
    step("run4",   0, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h00003010, 0, 0, 0);
    // branch with delay slot
    step("br",     0, 0, 0, 0, 1, 2'd1, 32'h00003100, 32'h0,        32'h00003100, 1, 0, 0);
    step("br+1",   0, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h00003104, 0, 0, 0);
    // land on 0x3020 as a delay slot, then stall with bd_F held high
    step("to3020", 0, 0, 0, 0, 1, 2'd1, 32'h00003020, 32'h0,        32'h00003020, 1, 0, 0);
    step("stl1",   0, 1, 0, 0, 0, 2'd1, 32'h00003abc, 32'h0,        32'h00003020, 1, 0, 0);
    step("stl2",   0, 1, 0, 0, 0, 2'd1, 32'h00003abc, 32'h0,        32'h00003020, 1, 0, 0);
    step("stl3",   0, 1, 0, 0, 0, 2'd1, 32'h00003abc, 32'h0,        32'h00003020, 1, 0, 0);
    step("stlert", 0, 1, 0, 1, 0, 2'd1, 32'h00003abc, 32'h00003044, 32'h00003020, 1, 0, 0);
    step("stlexc", 0, 1, 1, 0, 0, 2'd1, 32'h00003abc, 32'h0,        32'h00004180, 0, 1, 0);
    step("exc+1",  0, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h00004184, 0, 0, 0);
    // ERET, back-to-back ERET keeps kill high
    step("eret1",  0, 0, 0, 1, 1, 2'd1, 32'h00003abc, 32'h00003044, 32'h00003044, 0, 1, 0);
    step("eret2",  0, 0, 0, 1, 0, 2'd0, 32'h0,        32'h00003048, 32'h00003048, 0, 1, 0);
    step("eret+1", 0, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h0000304c, 0, 0, 0);
    // address error
    step("mis",    0, 0, 0, 0, 0, 2'd1, 32'h00003002, 32'h0,        32'h00003002, 0, 0, 1);
    step("hi+",    0, 0, 0, 0, 0, 2'd1, 32'h00007000, 32'h0,        32'h00007000, 0, 0, 1);
    step("hi",     0, 0, 0, 0, 0, 2'd1, 32'h00006ffc, 32'h0,        32'h00006ffc, 0, 0, 0);
    step("lo-",    0, 0, 0, 0, 0, 2'd1, 32'h00002ffc, 32'h0,        32'h00002ffc, 0, 0, 1);
    step("adelx",  0, 0, 1, 0, 0, 2'd1, 32'h00002ffc, 32'h0,        32'h00004180, 0, 1, 0);
    // misaligned epc surfaces as adel_F next cycle
    step("epcmis", 0, 0, 0, 1, 0, 2'd0, 32'h0,        32'h00003046, 32'h00003046, 0, 1, 1);
    // out-of-range sel, then reset over stall+exc
    step("sel3",   0, 0, 0, 0, 1, 2'd3, 32'h00005000, 32'h0,        32'h00003000, 1, 0, 0);
    step("run5",   0, 0, 0, 0, 1, 2'd0, 32'h0,        32'h0,        32'h00003004, 1, 0, 0);
    step("rstmid", 1, 1, 1, 1, 1, 2'd1, 32'h00005000, 32'h00003044, 32'h00003000, 0, 0, 0);
    step("rst+1",  0, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h00003004, 0, 0, 0);
    // wrap of pc_plus4
    step("wrap",   0, 0, 0, 0, 0, 2'd1, 32'hfffffffc, 32'h0,        32'hfffffffc, 0, 0, 1);
    step("wrap+1", 0, 0, 0, 0, 0, 2'd0, 32'h0,        32'h0,        32'h00000000, 0, 0, 1);
    step("sel2",   0, 0, 0, 0, 0, 2'd2, 32'h0,        32'h0,        32'h00000000, 0, 0, 1);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
